// File: rtl/sram_port_ctrl_if.sv
//------------------------------------------------------------------------------
// Module  : sram_port_ctrl_if
// Brief   : Fetch and load/store request/response bundle for sram_port_ctrl.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sram_port_ctrl_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    logic                  if_req;
    logic [ADDR_W-2:0]     if_addr;
    logic                  if_done;
    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_W-2:0]     dm_addr;
    logic [2*DATA_W-1:0]   dm_wdata;
    logic                  dm_done;
    logic [2*DATA_W-1:0]   rdata;

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        input  if_done, dm_done, rdata
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        output if_done, dm_done, rdata
    );
endinterface

`default_nettype wire

// File: rtl/sram_port_ctrl.sv
//------------------------------------------------------------------------------
// Module  : sram_port_ctrl
// Brief   : Two-master 32-bit word port onto a 16-bit single-port SRAM.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sram_port_ctrl #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
) (
    input  wire                 clk,
    input  wire                 rst_n,
    sram_port_ctrl_if.slave     host,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic                sram_we,
    output logic                sram_re,
    inout  wire  [DATA_W-1:0]   sram_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic                 w_grant_dm;
    logic                 w_grant_if;
    logic [ADDR_W-2:0]    w_sel_word;
    logic                 w_sel_we;

    logic [ADDR_W-2:0]    r_word;
    logic                 r_we;
    logic                 r_own_dm;
    logic [DATA_W-1:0]    r_wdata_hi;
    logic                 r_bus_oe;
    logic [DATA_W-1:0]    r_bus_data;
    logic [DATA_W-1:0]    r_rdata_lo;

    assign sram_data = r_bus_oe ? r_bus_data : {DATA_W{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // A master whose done is high this cycle is masked so the other gets a slot.
    always_comb begin
        w_grant_dm = 1'b0;
        w_grant_if = 1'b0;
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (host.dm_req && !host.dm_done) begin
                    w_grant_dm = 1'b1;
                end else if (host.if_req && !host.if_done) begin
                    w_grant_if = 1'b1;
                end
                if (w_grant_dm || w_grant_if) begin
                    w_state_nx = S_LO;
                end
            end
            S_LO:    w_state_nx = S_HI;
            S_HI:    w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
        w_sel_word = w_grant_dm ? host.dm_addr : host.if_addr;
        w_sel_we   = w_grant_dm & host.dm_we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_addr    <= '0;
            sram_we      <= 1'b0;
            sram_re      <= 1'b0;
            r_bus_oe     <= 1'b0;
            r_bus_data   <= '0;
            r_word       <= '0;
            r_we         <= 1'b0;
            r_own_dm     <= 1'b0;
            r_wdata_hi   <= '0;
            r_rdata_lo   <= '0;
            host.rdata   <= '0;
            host.if_done <= 1'b0;
            host.dm_done <= 1'b0;
        end else begin
            host.if_done <= 1'b0;
            host.dm_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_dm || w_grant_if) begin
                        r_word     <= w_sel_word;
                        r_we       <= w_sel_we;
                        r_own_dm   <= w_grant_dm;
                        r_wdata_hi <= host.dm_wdata[2*DATA_W-1:DATA_W];
                        sram_addr  <= {w_sel_word, 1'b0};
                        sram_we    <= w_sel_we;
                        sram_re    <= ~w_sel_we;
                        r_bus_oe   <= w_sel_we;
                        r_bus_data <= host.dm_wdata[DATA_W-1:0];
                    end
                end
                S_LO: begin
                    r_rdata_lo <= sram_data;
                    sram_addr  <= {r_word, 1'b1};
                    r_bus_data <= r_wdata_hi;
                end
                S_HI: begin
                    // Read data and done are published together on the closing edge.
                    if (!r_we) begin
                        host.rdata <= {sram_data, r_rdata_lo};
                    end
                    sram_we  <= 1'b0;
                    sram_re  <= 1'b0;
                    r_bus_oe <= 1'b0;
                    if (r_own_dm) begin
                        host.dm_done <= 1'b1;
                    end else begin
                        host.if_done <= 1'b1;
                    end
                end
                default: begin
                    sram_we  <= 1'b0;
                    sram_re  <= 1'b0;
                    r_bus_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_port_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_sram_port_ctrl
// Brief   : Directed bench for sram_port_ctrl with a behavioural SRAM.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sram_port_ctrl;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_we;
    logic              sram_re;
    wire  [DATA_W-1:0] sram_data;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic              pl_en = 1'b0;
    logic [ADDR_W-1:0] pl_addr = '0;
    logic [DATA_W-1:0] pl_data = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int n_done   = 0;
    logic mon_en   = 1'b0;
    logic prev_act = 1'b0;

    always #5 clk = ~clk;

    sram_port_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) host ();

    sram_port_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .host      (host),
        .sram_addr (sram_addr),
        .sram_we   (sram_we),
        .sram_re   (sram_re),
        .sram_data (sram_data)
    );

    // Combinational-read, edge-commit SRAM; preload port shares the write process.
    assign sram_data = sram_re ? mem[sram_addr] : {DATA_W{1'bz}};
    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= sram_data;
        else if (pl_en) mem[pl_addr] <= pl_data;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic clear_inputs();
        host.if_req   = 1'b0;
        host.if_addr  = '0;
        host.dm_req   = 1'b0;
        host.dm_we    = 1'b0;
        host.dm_addr  = '0;
        host.dm_wdata = '0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check_val("we_re_excl", 32'(sram_we & sram_re), 32'd0);
            check_val("oe_only_we", 32'(dut.r_bus_oe), 32'(sram_we));
            check_val("done_excl", 32'(host.if_done & host.dm_done), 32'd0);
            if (mon_en) begin
                if ((sram_we | sram_re) && !prev_act) n_acc++;
                if (host.if_done | host.dm_done) n_done++;
            end
        end
        prev_act = sram_we | sram_re;
    end

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            host.if_req   = 1'($urandom_range(1, 0));
            host.dm_req   = 1'($urandom_range(1, 0));
            host.dm_we    = 1'($urandom_range(1, 0));
            host.if_addr  = 10'($urandom);
            host.dm_addr  = 10'($urandom);
            host.dm_wdata = $urandom;
        end
        @(negedge clk);
        check_val("rst_we", 32'(sram_we), 32'd0);
        check_val("rst_re", 32'(sram_re), 32'd0);
        check_val("rst_oe", 32'(dut.r_bus_oe), 32'd0);
        check_val("rst_addr", 32'(sram_addr), 32'd0);
        check_val("rst_rdata", host.rdata, 32'd0);
        check_val("rst_done", 32'({host.if_done, host.dm_done}), 32'd0);
        clear_inputs();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("idle_active", 32'({sram_we, sram_re}), 32'd0);
        check_val("idle_done", 32'({host.if_done, host.dm_done}), 32'd0);

        // Store 0xDEADBEEF at word 0x005; request dropped right after acceptance.
        host.dm_req = 1'b1; host.dm_we = 1'b1; host.dm_addr = 10'h005; host.dm_wdata = 32'hDEADBEEF;
        @(negedge clk);
        host.dm_req = 1'b0;
        check_val("wr_lo_addr", 32'(sram_addr), 32'h00A);
        check_val("wr_lo_we", 32'({sram_we, sram_re}), 32'h2);
        check_val("wr_lo_bus", 32'(sram_data), 32'hBEEF);
        @(negedge clk);
        check_val("wr_hi_addr", 32'(sram_addr), 32'h00B);
        check_val("wr_hi_we", 32'({sram_we, sram_re}), 32'h2);
        check_val("wr_hi_bus", 32'(sram_data), 32'hDEAD);
        @(negedge clk);
        check_val("wr_done", 32'({host.dm_done, host.if_done}), 32'h2);
        check_val("wr_idle", 32'({sram_we, sram_re}), 32'd0);
        check_val("wr_mem_lo", 32'(mem[11'h00A]), 32'hBEEF);
        check_val("wr_mem_hi", 32'(mem[11'h00B]), 32'hDEAD);
        @(negedge clk);
        check_val("wr_done_pulse", 32'(host.dm_done), 32'd0);

        // Load word 0x005 back.
        host.dm_req = 1'b1; host.dm_we = 1'b0; host.dm_addr = 10'h005;
        @(negedge clk);
        host.dm_req = 1'b0;
        check_val("rd_lo_addr", 32'(sram_addr), 32'h00A);
        check_val("rd_lo_re", 32'({sram_we, sram_re}), 32'h1);
        @(negedge clk);
        check_val("rd_hi_addr", 32'(sram_addr), 32'h00B);
        @(negedge clk);
        check_val("rd_done", 32'(host.dm_done), 32'd1);
        check_val("rd_data", host.rdata, 32'hDEADBEEF);
        @(negedge clk);

        // Both masters request together and hold.
        preload(11'h00C, 16'h5555);
        preload(11'h00D, 16'h6666);
        host.dm_req = 1'b1; host.dm_we = 1'b0; host.dm_addr = 10'h005;
        host.if_req = 1'b1; host.if_addr = 10'h006;
        @(negedge clk);
        check_val("arb_first", 32'(sram_addr), 32'h00A);
        repeat (2) @(negedge clk);
        check_val("arb_dm_done", 32'({host.dm_done, host.if_done}), 32'h2);
        check_val("arb_dm_data", host.rdata, 32'hDEADBEEF);
        @(negedge clk);
        check_val("arb_if_lo", 32'(sram_addr), 32'h00C);
        repeat (2) @(negedge clk);
        check_val("arb_if_done", 32'({host.dm_done, host.if_done}), 32'h1);
        check_val("arb_if_data", host.rdata, 32'h66665555);
        @(negedge clk);
        host.dm_req = 1'b0; host.if_req = 1'b0;
        check_val("arb_dm_again", 32'(sram_addr), 32'h00A);
        repeat (2) @(negedge clk);
        check_val("arb_dm_done2", 32'({host.dm_done, host.if_done}), 32'h2);
        @(negedge clk);

        // Fetch at the top word address.
        preload(11'h7FE, 16'h1234);
        preload(11'h7FF, 16'hABCD);
        host.if_req = 1'b1; host.if_addr = 10'h3FF;
        @(negedge clk);
        host.if_req = 1'b0;
        check_val("top_lo_addr", 32'(sram_addr), 32'h7FE);
        @(negedge clk);
        check_val("top_hi_addr", 32'(sram_addr), 32'h7FF);
        @(negedge clk);
        check_val("top_done", 32'({host.dm_done, host.if_done}), 32'h1);
        check_val("top_data", host.rdata, 32'hABCD1234);
        @(negedge clk);

        // Write interrupted by reset in the high half.
        preload(11'h020, 16'hFFFF);
        preload(11'h021, 16'hFFFF);
        host.dm_req = 1'b1; host.dm_we = 1'b1; host.dm_addr = 10'h010; host.dm_wdata = 32'h0;
        @(negedge clk);
        host.dm_req = 1'b0;
        check_val("abort_lo_addr", 32'(sram_addr), 32'h020);
        @(negedge clk);
        check_val("abort_hi_addr", 32'(sram_addr), 32'h021);
        rst_n = 1'b0;
        #1;
        check_val("abort_we", 32'({sram_we, sram_re}), 32'd0);
        check_val("abort_oe", 32'(dut.r_bus_oe), 32'd0);
        @(negedge clk);
        check_val("abort_nodone", 32'({host.dm_done, host.if_done}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("abort_nodone2", 32'({host.dm_done, host.if_done}), 32'd0);
        check_val("abort_mem", 32'({mem[11'h021], mem[11'h020]}), 32'hFFFF0000);
        host.dm_req = 1'b1; host.dm_we = 1'b0; host.dm_addr = 10'h010;
        @(negedge clk);
        host.dm_req = 1'b0;
        repeat (2) @(negedge clk);
        check_val("abort_rb_done", 32'(host.dm_done), 32'd1);
        check_val("abort_rb_data", host.rdata, 32'hFFFF0000);
        @(negedge clk);

        // Random traffic: invariants and one done per accepted access.
        n_acc  = 0;
        n_done = 0;
        mon_en = 1'b1;
        repeat (300) begin
            host.dm_req   = ($urandom_range(3, 0) == 0);
            host.dm_we    = 1'($urandom_range(1, 0));
            host.dm_addr  = 10'($urandom);
            host.dm_wdata = $urandom;
            host.if_req   = ($urandom_range(2, 0) == 0);
            host.if_addr  = 10'($urandom);
            @(negedge clk);
        end
        clear_inputs();
        repeat (8) @(negedge clk);
        mon_en = 1'b0;
        check_val("rand_some_acc", 32'(n_acc > 10), 32'd1);
        check_val("rand_done_cnt", 32'(n_done), 32'(n_acc));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
